// File: rtl/timer_controller.sv
// timer_controller: sequencing FSM for a BCD stopwatch/countdown datapath.
// Decides when the datapath loads its start value, when it may count, which
// direction it counts, and when the count has reached its terminal value.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-low
//   tick_10ms           10 ms pulse, only used to accumulate run_ticks
//   start_stop          one-cycle pulse, toggles run/pause
//   load_req            one-cycle pulse, requests a reload with the current mode
//   mode[1:0]           00 up from 00.00, 01 down from 99.99, 10 up/11 down from preset
//   ms_ones..sec_tens   live BCD digits from the datapath
//   load                one-cycle pulse, datapath loads its start value
//   count_enable        datapath may count (combinational, drops at terminal)
//   up                  count direction, 1 = up
//   active_mode[1:0]    mode captured at the last load
//   done, done_pulse    level while finished / one cycle on entry
//   state[2:0]          current FSM encoding
//   run_ticks[15:0]     saturating count of ticks seen while counting
module timer_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_10ms,
    input  logic        start_stop,
    input  logic        load_req,
    input  logic [1:0]  mode,
    input  logic [3:0]  ms_ones,
    input  logic [3:0]  ms_tens,
    input  logic [3:0]  sec_ones,
    input  logic [3:0]  sec_tens,
    output logic        load,
    output logic        count_enable,
    output logic        up,
    output logic [1:0]  active_mode,
    output logic        done,
    output logic        done_pulse,
    output logic [2:0]  state,
    output logic [15:0] run_ticks
);

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StLoad  = 3'b001,
        StReady = 3'b010,
        StRun   = 3'b011,
        StPause = 3'b100,
        StDone  = 3'b101
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  active_mode_q, active_mode_d;
    logic        up_q, up_d;
    logic        load_q, load_d;
    logic        done_q, done_d;
    logic        done_pulse_q, done_pulse_d;
    logic [15:0] run_ticks_q, run_ticks_d;
    logic        terminal;

    // Down modes stop at 00.00, up modes stop at 99.99.
    always_comb begin
        if (active_mode_q[0]) begin
            terminal = (sec_tens == 4'd0) && (sec_ones == 4'd0) &&
                       (ms_tens == 4'd0) && (ms_ones == 4'd0);
        end else begin
            terminal = (sec_tens == 4'd9) && (sec_ones == 4'd9) &&
                       (ms_tens == 4'd9) && (ms_ones == 4'd9);
        end
    end

    // Combinational so the datapath is frozen in the same cycle terminal appears.
    assign count_enable = (state_q == StRun) && !terminal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (load_req || start_stop) state_d = StLoad;
            end
            StLoad: state_d = StReady;
            StReady, StPause: begin
                if (load_req)        state_d = StLoad;
                else if (start_stop) state_d = StRun;
            end
            StRun: begin
                if (terminal)        state_d = StDone;
                else if (load_req)   state_d = StLoad;
                else if (start_stop) state_d = StPause;
            end
            StDone: begin
                if (load_req || start_stop) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active_mode_d = (state_d == StLoad) ? mode : active_mode_q;
        // Direction follows the mode being latched, so it is valid before RUN.
        up_d          = ~active_mode_d[0];
        load_d        = (state_d == StLoad);
        done_d        = (state_d == StDone);
        done_pulse_d  = (state_d == StDone) && (state_q != StDone);

        run_ticks_d = run_ticks_q;
        if (state_d == StLoad) begin
            run_ticks_d = 16'd0;
        end else if (count_enable && tick_10ms && (run_ticks_q != 16'hFFFF)) begin
            run_ticks_d = run_ticks_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            active_mode_q <= 2'b00;
            up_q          <= 1'b1;
            load_q        <= 1'b0;
            done_q        <= 1'b0;
            done_pulse_q  <= 1'b0;
            run_ticks_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            active_mode_q <= active_mode_d;
            up_q          <= up_d;
            load_q        <= load_d;
            done_q        <= done_d;
            done_pulse_q  <= done_pulse_d;
            run_ticks_q   <= run_ticks_d;
        end
    end

    assign state       = state_q;
    assign active_mode = active_mode_q;
    assign up          = up_q;
    assign load        = load_q;
    assign done        = done_q;
    assign done_pulse  = done_pulse_q;
    assign run_ticks   = run_ticks_q;

endmodule

// File: doc/timer_controller.md
TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 SHALL have the ports listed below.
- clk, input, 1 bit: system clock; all state changes on the rising edge.
- reset, input, 1 bit: synchronous, active-low; when low at a rising edge, the block enters its reset state.
- tick_10ms, input, 1 bit: one-cycle pulse every 10 ms, used only for the status output.
- start_stop, input, 1 bit: debounced one-cycle pulse that toggles run/pause.
- load_req, input, 1 bit: debounced one-cycle pulse that requests a reload with the current mode.
- mode, input, 2 bits: 00 up from 00.00; 01 down from 99.99; 10 up from preset; 11 down from preset.
- ms_ones, ms_tens, sec_ones, sec_tens, input, 4 bits each: live BCD count fed back from the datapath.
- load, output, 1 bit: one-cycle pulse that makes the datapath load its mode-dependent start value.
- count_enable, output, 1 bit: allows the datapath to count on clk_10ms.
- up, output, 1 bit: count direction; 1 = up.
- active_mode, output, 2 bits: the mode latched at the last load.
- done, output, 1 bit: level, high while in DONE.
- done_pulse, output, 1 bit: one cycle wide, on entry to DONE.
- state, output, 3 bits: current FSM state encoding.
- run_ticks, output, 16 bits: number of tick_10ms pulses counted in RUN since the last load.

Function
REQ-002 SHALL implement the FSM states IDLE=000, LOAD=001, READY=010, RUN=011, PAUSE=100, DONE=101; encodings 110 and 111 SHALL go to IDLE on the next edge.
REQ-003 In IDLE:
- load_req or start_stop -> LOAD;
- otherwise stay in IDLE.
REQ-004 On every transition into LOAD, active_mode SHALL latch mode; mode is ignored at all other times.
REQ-005 In LOAD:
- load=1 for exactly that one cycle;
- run_ticks cleared to 0;
- next state is unconditionally READY.
REQ-006 In READY:
- load_req -> LOAD;
- else start_stop -> RUN;
- else stay.
REQ-007 In RUN, priority from highest to lowest:
- terminal (REQ-010) -> DONE;
- load_req -> LOAD;
- start_stop -> PAUSE;
- else stay.
REQ-008 In PAUSE:
- load_req -> LOAD;
- else start_stop -> RUN;
- else stay.
REQ-009 In DONE: load_req or start_stop -> LOAD (automatic reload); else stay.
REQ-010 terminal SHALL be combinational:
- active_mode[0]=0: true when the digits read 9,9,9,9 (99.99);
- active_mode[0]=1: true when the digits read 0,0,0,0 (00.00).
REQ-011 up SHALL equal NOT active_mode[0] and be registered, so it is stable before the first count.
REQ-012 count_enable SHALL equal (state==RUN) AND NOT terminal, combinational, so the datapath never passes the terminal value.
REQ-013 done SHALL be 1 iff state==DONE.
REQ-014 done_pulse SHALL be 1 only on the first cycle in DONE.
REQ-015 run_ticks SHALL increment on tick_10ms only while count_enable=1, and saturate at 16'hFFFF.
REQ-016 Simultaneous load_req and start_stop SHALL be treated as load_req, except that terminal in RUN overrides both.
REQ-017 Latency rules:
- a request pulse changes state on the next edge;
- load rises one cycle after load_req (IDLE → LOAD);
- count_enable rises one cycle after start_stop in READY or PAUSE.
REQ-018 Start-at-terminal: if the count equals the terminal value on entering RUN (e.g. mode 11 with preset 00), the block SHALL go to DONE on the next edge with no count_enable pulse.

Reset
REQ-019 While reset=0 at a clock edge:
- state=IDLE;
- load=0, count_enable=0, done=0, done_pulse=0;
- active_mode=00, up=1, run_ticks=0.
REQ-020 Reset SHALL take effect in any state, including mid-RUN and mid-LOAD, and override all other inputs in that cycle.
REQ-021 No output SHALL change between clock edges except count_enable, which follows the terminal input combinationally.

Verification
REQ-022 The bench SHALL cover the scenarios below.
- Mode 00 full run: load_req, then start_stop; drive the digits up to 99.99 → count_enable drops the same cycle, done_pulse fires once, state=101, up=1.
- Mode 01 pause: load, run, start_stop mid-count → state=100, count_enable=0; start_stop again → RUN, count_enable=1, run_ticks continues from its held value.
- Mode 11 with preset 00: load_req, then start_stop → DONE next cycle, count_enable never high, run_ticks=0.
- Mode change during RUN from 00 to 01 → active_mode stays 00 and up stays 1 until the next load_req, after which active_mode=01 and up=0.
- Simultaneous pulses: load_req and start_stop together in READY → LOAD; in RUN with terminal true → DONE.
- Reset mid-RUN: reset=0 for one edge → IDLE with all outputs at their REQ-019 values; the next load_req gives load=1 one cycle later.
